cpu_controller: RTL
===================

Name: cpu_controller

Overview:
- Moore finite state machine (FSM) that sequences the 16-bit datapath through one instruction at a time.
- Consumes opcode/op from the instruction decoder.
- Drives the decoder's register-select (nsel) and all datapath load/mux/write enables.
- Handshakes with the top level through the start (s) and waiting (w) signals.

Parameters:
- STATUS_ON_ALL, 0: 1 = loads asserted in S_ALU for every ALU-class (opcode 101) instruction; 0 = loads asserted only for CMP.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high
- s  input  1  start request; sampled only in S_WAIT
- opcode  input  3  instruction bits [15:13] from decoder
- op  input  2  instruction bits [12:11] from decoder
- w  output  1  high when idle in S_WAIT
- nsel  output  3  register select to decoder: 001=Rm, 010=Rd, 100=Rn, 000=none
- loada  output  1  load A register
- loadb  output  1  load B register
- asel  output  1  1 = ALU A input forced to 0
- bsel  output  1  1 = ALU B input takes sximm5 (always 0 in this instruction set)
- loadc  output  1  load C register
- loads  output  1  load status register
- vsel  output  2  writeback source: 00=C, 10=sximm8 (01, 11 reserved, never driven)
- write  output  1  register file write enable
- illegal  output  1  one-cycle pulse on unsupported opcode/op

Behaviour:
- Reset: state = S_WAIT; latched opcode/op = 0; w=1; all other outputs 0; nsel=000.
  - Asynchronous: outputs reach reset values without a clock edge, including mid-instruction; no partial write occurs after reset asserts.
- Output decoding:
  - All outputs are pure Moore decodes of state, plus the latched opcode/op.
  - Any output not listed for a state is 0.
- Instruction capture:
  - In S_WAIT with s=1, opcode/op are latched on the clock edge into internal registers.
  - All later decisions use the latched copies; inputs may change freely after that edge.
- States and transitions (one clock each):
  - S_WAIT: w=1. s=1 -> S_DECODE, else stay.
  - S_DECODE: no enables. Branches on the latched {opcode, op}:
    - 110_10 (MOV imm) -> S_WRITE_IMM
    - 110_00 (MOV reg) -> S_GET_B
    - 101_11 (MVN) -> S_GET_B
    - 101_00/01/10 (ADD/CMP/AND) -> S_GET_A
    - anything else -> S_WAIT, with illegal=1 for this cycle
  - S_GET_A: nsel=100, loada=1 -> S_GET_B.
  - S_GET_B: nsel=001, loadb=1 -> S_ALU.
  - S_ALU: bsel=0.
    - asel=1 for MOV reg and MVN; asel=0 otherwise.
    - CMP: loads=1, loadc=0 -> S_WAIT.
    - Others: loadc=1; loads=STATUS_ON_ALL for ADD/AND/MVN, 0 for MOV reg -> S_WRITE_REG.
  - S_WRITE_REG: nsel=010, vsel=00, write=1 -> S_WAIT.
  - S_WRITE_IMM: nsel=100, vsel=10, write=1 -> S_WAIT.
- Latency, counted from the edge that samples s=1 to the return of w=1:
  - MOV imm: 3 cycles.
  - MOV reg / MVN: 5 cycles.
  - CMP: 5 cycles.
  - ADD / AND: 6 cycles.
  - Illegal: 2 cycles.
- Boundary conditions:
  - s outside S_WAIT is ignored.
  - s held high continuously starts the next instruction on the first S_WAIT cycle (back-to-back; w high for exactly 1 cycle).
  - write and loads are never both 1 in the same cycle.
  - Exactly one nsel bit is set whenever loada, loadb or write is 1.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state enum (7 states, 3-bit encoding)
  - opcode constants (OP_MOV=110, OP_ALU=101)
  - ALU op constants (ADD=00, CMP=01, AND=10, MVN=11)
  - NSEL_RM/RD/RN/NONE constants
  - VSEL_C/VSEL_IMM8 constants
- Single module; no sub-module is warranted.
- Next-state logic and output decode are separate combinational blocks; the state and instruction-latch flops are in one asynchronous-reset sequential block.

Test Plan:
- Reset mid-instruction: assert reset during S_ALU of an ADD -> w=1, write=0, loadc=0 immediately, before the next edge; after release, idles in S_WAIT.
- MOV imm: opcode=110, op=10, s pulsed 1 cycle -> exactly one cycle with write=1, nsel=100, vsel=10, 2 cycles after the s edge; w high again on cycle 3.
- ADD: opcode=101, op=00; opcode driven to 000 one cycle after s -> sequence loada(nsel=100), loadb(nsel=001), loadc(asel=0), write(nsel=010, vsel=00); w returns after 6 cycles.
- CMP with STATUS_ON_ALL=0 -> loads=1 in S_ALU, loadc=0, write never asserted; w after 5 cycles. Repeat ADD: loads=0 throughout.
- Illegal opcode=111, op=00 -> illegal=1 for exactly one cycle in S_DECODE, no enables asserted, w=1 two cycles after start.
- s held high across three consecutive MVN instructions -> each shows asel=1, loadc=1, write=1 with nsel=010; w high for exactly one cycle between instructions; s pulses while busy leave the sequence unchanged.

Source files
------------

// File: rtl/cpu_controller_pkg.sv
// ----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared types and constants for the cpu_controller sequencer.
//   state_t      : seven controller states, 3-bit encoding
//   OP_*         : instruction class opcodes (bits [15:13])
//   ALU_*, MOV_* : sub-operation codes (bits [12:11])
//   NSEL_*       : one-hot register selects toward the instruction decoder
//   VSEL_*       : writeback source selects
//   decode_next  : the state that follows S_DECODE for a given instruction
// ----------------------------------------------------------------------------
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_GET_A     = 3'd2,
    S_GET_B     = 3'd3,
    S_ALU       = 3'd4,
    S_WRITE_REG = 3'd5,
    S_WRITE_IMM = 3'd6
  } state_t;

  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_ALU = 3'b101;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic [1:0] MOV_REG = 2'b00;
  localparam logic [1:0] MOV_IMM = 2'b10;

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RM   = 3'b001;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RN   = 3'b100;

  localparam logic [1:0] VSEL_C    = 2'b00;
  localparam logic [1:0] VSEL_IMM8 = 2'b10;

  // Instruction dispatch out of S_DECODE. Unsupported encodings fall back to
  // S_WAIT; the controller uses that same result to raise 'illegal', so the
  // legality rule lives in exactly one place.
  function automatic state_t decode_next(input logic [2:0] opcode,
                                         input logic [1:0] op);
    state_t nxt;
    nxt = S_WAIT;
    if (opcode == OP_MOV) begin
      if (op == MOV_IMM)
        nxt = S_WRITE_IMM;
      else if (op == MOV_REG)
        nxt = S_GET_B;
    end else if (opcode == OP_ALU) begin
      if (op == ALU_MVN)
        nxt = S_GET_B;
      else
        nxt = S_GET_A;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// ----------------------------------------------------------------------------
// cpu_controller_if
// Bundles the controller's handshake, instruction and datapath-control lines.
//   s, opcode, op      : start request and decoded instruction fields (to ctrl)
//   w                  : controller idle / ready for a new instruction
//   nsel               : register select back to the decoder
//   loada/loadb/loadc  : datapath register loads
//   loads              : status register load
//   asel/bsel          : ALU operand muxes
//   vsel, write        : register file writeback source and enable
//   illegal            : one-cycle pulse for an unsupported instruction
// modport master : the controller (drives every control output)
// modport slave  : the surrounding datapath / top level
// ----------------------------------------------------------------------------
interface cpu_controller_if;

  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;

  logic       w;
  logic [2:0] nsel;
  logic       loada;
  logic       loadb;
  logic       asel;
  logic       bsel;
  logic       loadc;
  logic       loads;
  logic [1:0] vsel;
  logic       write;
  logic       illegal;

  modport master (
    input  s, opcode, op,
    output w, nsel, loada, loadb, asel, bsel, loadc, loads, vsel, write, illegal
  );

  modport slave (
    output s, opcode, op,
    input  w, nsel, loada, loadb, asel, bsel, loadc, loads, vsel, write, illegal
  );

endinterface

// File: rtl/cpu_controller.sv
// ----------------------------------------------------------------------------
// cpu_controller
// Moore FSM that walks the 16-bit datapath through one instruction at a time.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; returns to S_WAIT immediately
//   bus   : cpu_controller_if.master (handshake, instruction fields, enables)
// Parameter:
//   STATUS_ON_ALL : 1 = status register also loads for ADD/AND/MVN,
//                   0 = status register loads only for CMP
// ----------------------------------------------------------------------------
module cpu_controller #(
  parameter bit STATUS_ON_ALL = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  cpu_controller_if.master  bus
);
  import cpu_ctrl_pkg::*;

  state_t     state;
  state_t     state_next;
  logic [2:0] opcode_q;
  logic [1:0] op_q;

  // Latched-instruction classifications used by the S_ALU decode.
  logic is_cmp;
  logic is_mov_reg;
  logic is_mvn;

  assign is_cmp     = (opcode_q == OP_ALU) && (op_q == ALU_CMP);
  assign is_mov_reg = (opcode_q == OP_MOV) && (op_q == MOV_REG);
  assign is_mvn     = (opcode_q == OP_ALU) && (op_q == ALU_MVN);

  // State register and instruction latch. The instruction is captured only on
  // the edge that accepts a start, so the decoder inputs are free to change
  // while the instruction is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_WAIT;
      opcode_q <= '0;
      op_q     <= '0;
    end else begin
      state <= state_next;
      if ((state == S_WAIT) && bus.s) begin
        opcode_q <= bus.opcode;
        op_q     <= bus.op;
      end
    end
  end

  // Next-state logic. Every state except S_WAIT lasts exactly one clock, and
  // 's' is only looked at in S_WAIT, so a start request while busy is dropped.
  always_comb begin
    state_next = state;
    case (state)
      S_WAIT:      if (bus.s) state_next = S_DECODE;
      S_DECODE:    state_next = decode_next(opcode_q, op_q);
      S_GET_A:     state_next = S_GET_B;
      S_GET_B:     state_next = S_ALU;
      S_ALU:       state_next = is_cmp ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_next = S_WAIT;
      S_WRITE_IMM: state_next = S_WAIT;
      default:     state_next = S_WAIT;
    endcase
  end

  // Moore output decode from the state and latched instruction only. Because
  // nothing here is registered, an asynchronous reset forces the idle pattern
  // immediately, so an in-flight write cannot complete after reset asserts.
  logic       w_d;
  logic [2:0] nsel_d;
  logic       loada_d;
  logic       loadb_d;
  logic       asel_d;
  logic       loadc_d;
  logic       loads_d;
  logic [1:0] vsel_d;
  logic       write_d;
  logic       illegal_d;

  always_comb begin
    w_d       = 1'b0;
    nsel_d    = NSEL_NONE;
    loada_d   = 1'b0;
    loadb_d   = 1'b0;
    asel_d    = 1'b0;
    loadc_d   = 1'b0;
    loads_d   = 1'b0;
    vsel_d    = VSEL_C;
    write_d   = 1'b0;
    illegal_d = 1'b0;
    case (state)
      S_WAIT: begin
        w_d = 1'b1;
      end
      S_DECODE: begin
        illegal_d = (decode_next(opcode_q, op_q) == S_WAIT);
      end
      S_GET_A: begin
        nsel_d  = NSEL_RN;
        loada_d = 1'b1;
      end
      S_GET_B: begin
        nsel_d  = NSEL_RM;
        loadb_d = 1'b1;
      end
      S_ALU: begin
        // MOV reg and MVN pass only the B operand, so A is forced to zero.
        asel_d = is_mov_reg || is_mvn;
        if (is_cmp) begin
          loads_d = 1'b1;
        end else begin
          loadc_d = 1'b1;
          loads_d = is_mov_reg ? 1'b0 : STATUS_ON_ALL;
        end
      end
      S_WRITE_REG: begin
        nsel_d  = NSEL_RD;
        vsel_d  = VSEL_C;
        write_d = 1'b1;
      end
      S_WRITE_IMM: begin
        nsel_d  = NSEL_RN;
        vsel_d  = VSEL_IMM8;
        write_d = 1'b1;
      end
      default: begin
        w_d = 1'b0;
      end
    endcase
  end

  assign bus.w       = w_d;
  assign bus.nsel    = nsel_d;
  assign bus.loada   = loada_d;
  assign bus.loadb   = loadb_d;
  assign bus.asel    = asel_d;
  assign bus.bsel    = 1'b0;
  assign bus.loadc   = loadc_d;
  assign bus.loads   = loads_d;
  assign bus.vsel    = vsel_d;
  assign bus.write   = write_d;
  assign bus.illegal = illegal_d;

endmodule
